// File: rtl/accelerator_sequencer_pkg.sv
// accelerator_sequencer_pkg
// Shared types and constants for the matrix stream sequencer:
//   seq_state_t  - sequencer FSM state encoding (IDLE / FETCH / PRESENT)
//   MODE_VECTOR  - MODE value selecting a single-row transfer
//   MODE_MATRIX  - MODE value selecting an I x J transfer
package accelerator_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } seq_state_t;

  localparam logic MODE_VECTOR = 1'b0;
  localparam logic MODE_MATRIX = 1'b1;

endpackage

// File: rtl/accelerator_sequencer_counter.sv
// accelerator_sequencer_counter
// Two-dimensional i/j element counter. j runs fastest; when j reaches
// size_j-1 an increment wraps j to 0 and advances i. All arithmetic wraps
// modulo 2^INDEX_SIZE.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clr         - synchronous clear of both indices
//   inc         - advance to the next element
//   size_i/j    - effective row / column counts (non-zero while counting)
//   last        - current element is (size_i-1, size_j-1)
//   row_start   - current element is the first of a row (j == 0)
module accelerator_sequencer_counter #(
  parameter int INDEX_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [INDEX_SIZE-1:0] size_i,
  input  logic [INDEX_SIZE-1:0] size_j,
  output logic                  last,
  output logic                  row_start
);

  localparam logic [INDEX_SIZE-1:0] IDX_ONE = {{(INDEX_SIZE-1){1'b0}}, 1'b1};

  logic [INDEX_SIZE-1:0] idx_i;
  logic [INDEX_SIZE-1:0] idx_j;
  logic [INDEX_SIZE-1:0] max_i;
  logic [INDEX_SIZE-1:0] max_j;
  logic                  j_wrap;

  assign max_i     = size_i - IDX_ONE;
  assign max_j     = size_j - IDX_ONE;
  assign j_wrap    = (idx_j == max_j);
  assign last      = (idx_i == max_i) && j_wrap;
  assign row_start = (idx_j == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_i <= '0;
      idx_j <= '0;
    end else if (clr) begin
      idx_i <= '0;
      idx_j <= '0;
    end else if (inc) begin
      if (j_wrap) begin
        idx_j <= '0;
        idx_i <= idx_i + IDX_ONE;
      end else begin
        idx_j <= idx_j + IDX_ONE;
      end
    end
  end

endmodule

// File: rtl/accelerator_matrix_stream_sequencer.sv
// accelerator_matrix_stream_sequencer
// Pulls I x J elements from an upstream stream one at a time and presents
// each to a consumer until acknowledged, flagging the first element of
// every row. READY pulses once when the transfer completes.
//
// Handshakes:
//   upstream : an element moves when DATA_IN_VALID && DATA_IN_READY at a
//              rising CLK edge; DATA_IN_READY is high only in FETCH.
//   consumer : DATA_OUT / DATA_I_ENABLE are meaningful while DATA_J_ENABLE
//              is high and stay stable until DATA_OUT_ACK is seen in PRESENT.
//
// Ports:
//   CLK, RST              - clock, asynchronous active-high reset
//   START, MODE           - start request (IDLE only); 0 vector, 1 matrix
//   SIZE_I_IN, SIZE_J_IN  - row / column count, truncated to INDEX_SIZE bits
//   READY                 - one-cycle completion pulse
//   DATA_IN*, DATA_OUT*   - upstream and consumer sides as described above
//   DATA_I_ENABLE         - presented element starts a row
//   DATA_J_ENABLE         - presented element is valid
//   ABORT                 - only with ACCELERATOR_SEQUENCER_ABORT_EN defined:
//                           abandon the transfer and pulse READY
//   dbg_state             - current FSM state (seq_state_t encoding)
module accelerator_matrix_stream_sequencer
  import accelerator_sequencer_pkg::*;
#(
  parameter int DATA_SIZE  = 64,
  parameter int INDEX_SIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 MODE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic                 DATA_IN_VALID,
  output logic                 DATA_IN_READY,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_I_ENABLE,
  output logic                 DATA_J_ENABLE,
`ifdef ACCELERATOR_SEQUENCER_ABORT_EN
  input  logic                 ABORT,
`endif
  input  logic                 DATA_OUT_ACK,
  output logic [1:0]           dbg_state
);

  localparam logic [INDEX_SIZE-1:0] IDX_ONE = {{(INDEX_SIZE-1){1'b0}}, 1'b1};

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic                  mode_q;
  logic [INDEX_SIZE-1:0] size_i_q;
  logic [INDEX_SIZE-1:0] size_j_q;
  logic [INDEX_SIZE-1:0] eff_i_q;
  logic [INDEX_SIZE-1:0] eff_i_in;
  logic [INDEX_SIZE-1:0] size_j_in;
  logic                  start_seen;
  logic                  start_go;
  logic                  start_zero;
  logic                  accept;
  logic                  ack_take;
  logic                  abort_take;
  logic                  cnt_inc;
  logic                  cnt_last;
  logic                  cnt_row_start;
  logic                  unused_size_hi;

  // Size bits above INDEX_SIZE are dropped on purpose.
  assign unused_size_hi = ^{SIZE_I_IN[DATA_SIZE-1:INDEX_SIZE],
                            SIZE_J_IN[DATA_SIZE-1:INDEX_SIZE]};

  // Vector mode behaves as a single row regardless of SIZE_I_IN.
  assign size_j_in = SIZE_J_IN[INDEX_SIZE-1:0];
  assign eff_i_in  = (MODE == MODE_MATRIX) ? SIZE_I_IN[INDEX_SIZE-1:0] : IDX_ONE;
  assign eff_i_q   = (mode_q == MODE_MATRIX) ? size_i_q : IDX_ONE;

`ifdef ACCELERATOR_SEQUENCER_ABORT_EN
  assign abort_take = ABORT && (state != ST_IDLE);
`else
  assign abort_take = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_go) state_nxt = ST_FETCH;
      ST_FETCH:   if (abort_take) state_nxt = ST_IDLE;
                  else if (accept) state_nxt = ST_PRESENT;
      ST_PRESENT: if (abort_take) state_nxt = ST_IDLE;
                  else if (ack_take) state_nxt = cnt_last ? ST_IDLE : ST_FETCH;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    DATA_IN_READY = (state == ST_FETCH);
    dbg_state     = state;
    start_seen    = (state == ST_IDLE) && START;
    start_zero    = start_seen && ((eff_i_in == '0) || (size_j_in == '0));
    start_go      = start_seen && !start_zero;
    accept        = (state == ST_FETCH) && DATA_IN_VALID && !abort_take;
    ack_take      = (state == ST_PRESENT) && DATA_OUT_ACK && !abort_take;
    cnt_inc       = ack_take && !cnt_last;
  end

  // Datapath and completion pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY         <= 1'b0;
      DATA_OUT      <= '0;
      DATA_I_ENABLE <= 1'b0;
      DATA_J_ENABLE <= 1'b0;
      mode_q        <= 1'b0;
      size_i_q      <= '0;
      size_j_q      <= '0;
    end else begin
      READY <= start_zero || (ack_take && cnt_last) || abort_take;
      if (start_seen) begin
        mode_q   <= MODE;
        size_i_q <= SIZE_I_IN[INDEX_SIZE-1:0];
        size_j_q <= size_j_in;
      end
      if (accept) begin
        DATA_OUT      <= DATA_IN;
        DATA_J_ENABLE <= 1'b1;
        DATA_I_ENABLE <= cnt_row_start;
      end else if (ack_take || abort_take) begin
        DATA_J_ENABLE <= 1'b0;
        DATA_I_ENABLE <= 1'b0;
      end
    end
  end

  accelerator_sequencer_counter #(
    .INDEX_SIZE (INDEX_SIZE)
  ) u_counter (
    .clk       (CLK),
    .rst       (RST),
    .clr       (start_seen),
    .inc       (cnt_inc),
    .size_i    (eff_i_q),
    .size_j    (size_j_q),
    .last      (cnt_last),
    .row_start (cnt_row_start)
  );

endmodule
